sdram_bus_arbiter: RTL and testbench

SDRAM_BUS_ARBITER -- requirements
Module: sdram_bus_arbiter

---
 rtl/sdram_bus_arbiter_if.sv | 26 ++
 rtl/sdram_bus_arbiter.sv | 119 +++++++++++
 tb/tb_sdram_bus_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bus_arbiter_if.sv
// Bus-side signal bundle for sdram_bus_arbiter: requests and strobes in, grants and forced pulses out.
// arb_state mirrors the arbiter FSM (0 IDLE, 1 GRANTED, 2 ACTIVE, 3 RELEASE) for observation.
interface sdram_bus_arbiter_if;
    logic       ramInitBusy;
    logic [3:0] request;
    logic       beginTransactionIn;
    logic       endTransactionIn;
    logic       busErrorIn;
    logic [3:0] grant;
    logic       endTransactionOut;
    logic       busErrorOut;
    logic       arbiterBusy;
    logic [1:0] arb_state;

    // Handshake: a master holds request[n] until it sees grant[n]; it then strobes
    // beginTransactionIn for one cycle, and the transfer ends on endTransactionIn or busErrorIn.
    modport master (
        output ramInitBusy, request, beginTransactionIn, endTransactionIn, busErrorIn,
        input  grant, endTransactionOut, busErrorOut, arbiterBusy, arb_state
    );

    modport slave (
        input  ramInitBusy, request, beginTransactionIn, endTransactionIn, busErrorIn,
        output grant, endTransactionOut, busErrorOut, arbiterBusy, arb_state
    );
endinterface

// File: rtl/sdram_bus_arbiter.sv
// Four-master round-robin bus arbiter for the SDRAM bus with a registered one-hot grant.
// Define SDRAM_ARBITER_WATCHDOG_EN to add the ACTIVE-state transaction watchdog.
module sdram_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    sdram_bus_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] grant_q;
    logic [1:0] last_grant;
    logic [1:0] next_idx;
    logic [1:0] cand;
    logic       found;

    // Search starts one past the last winner, so the previous owner is considered last.
    always_comb begin
        found    = 1'b0;
        next_idx = last_grant;
        cand     = last_grant;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + k[1:0];
            if (!found && bus.request[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

`ifdef SDRAM_ARBITER_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_count;
    logic        end_q;
    logic        err_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= 4'b0000;
            last_grant <= 2'd3;
`ifdef SDRAM_ARBITER_WATCHDOG_EN
            wd_count   <= 16'd0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef SDRAM_ARBITER_WATCHDOG_EN
            end_q <= 1'b0;
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!bus.ramInitBusy && found) begin
                        grant_q    <= 4'b0001 << next_idx;
                        last_grant <= next_idx;
                        state      <= GRANTED;
                    end
                end
                GRANTED: begin
                    // Begin wins over a simultaneous request drop; end/error are meaningless here.
                    if (bus.beginTransactionIn) begin
                        state <= ACTIVE;
`ifdef SDRAM_ARBITER_WATCHDOG_EN
                        wd_count <= 16'd0;
`endif
                    end else if ((bus.request & grant_q) == 4'b0000) begin
                        grant_q <= 4'b0000;
                        state   <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (bus.endTransactionIn || bus.busErrorIn) begin
                        grant_q <= 4'b0000;
                        state   <= RELEASE;
                    end
`ifdef SDRAM_ARBITER_WATCHDOG_EN
                    else if (wd_count == WD_LIMIT) begin
                        grant_q <= 4'b0000;
                        state   <= RELEASE;
                        end_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        wd_count <= wd_count + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    grant_q <= 4'b0000;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= 4'b0000;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.arbiterBusy = (state != IDLE);
    assign bus.arb_state   = state;

`ifdef SDRAM_ARBITER_WATCHDOG_EN
    assign bus.endTransactionOut = end_q;
    assign bus.busErrorOut       = err_q;
`else
    assign bus.endTransactionOut = 1'b0;
    assign bus.busErrorOut       = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed testbench for sdram_bus_arbiter with a grant scoreboard; covers both
// SDRAM_ARBITER_WATCHDOG_EN builds.
module tb_sdram_bus_arbiter;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [3:0] exp_q[$];
    logic [3:0] prev_grant;
    logic [3:0] rr_exp[5];

    sdram_bus_arbiter_if bus();

    sdram_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Grant monitor: every fresh grant must match the oldest expected winner.
    initial prev_grant = 4'b0000;
    always @(negedge clock) begin
        if (!reset) begin
            check("onehot", 32'($onehot0(bus.grant)), 32'd1);
            if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
                if (exp_q.size() == 0) check("unexpected_grant", 32'(bus.grant), 32'd0);
                else check("sb_grant", 32'(bus.grant), 32'(exp_q.pop_front()));
            end
        end
        prev_grant = bus.grant;
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rr_exp[0] = 4'b0010;
        rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;
        rr_exp[4] = 4'b0010;
        reset = 1'b1;
        bus.ramInitBusy        = 1'b1;
        bus.request            = 4'b0000;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.arbiterBusy), 32'd0);
        check("rst_end", 32'(bus.endTransactionOut), 32'd0);
        check("rst_err", 32'(bus.busErrorOut), 32'd0);
        check("rst_state", 32'(bus.arb_state), 32'd0);
        reset = 1'b0;

        // Init gating, then master 0 one cycle after ramInitBusy falls
        bus.request = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("init_gate", 32'(bus.grant), 32'd0);
        end
        bus.ramInitBusy = 1'b0;
        exp_q.push_back(4'b0001);
        tick();
        check("init_grant", 32'(bus.grant), 32'b0001);
        check("init_busy", 32'(bus.arbiterBusy), 32'd1);
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        check("init_active", 32'(bus.arb_state), 32'd2);
        bus.endTransactionIn = 1'b1;
        tick();
        bus.endTransactionIn = 1'b0;
        bus.request = 4'b0000;
        check("init_release", 32'(bus.arb_state), 32'd3);
        check("init_rel_grant", 32'(bus.grant), 32'd0);
        tick();
        check("init_idle", 32'(bus.arbiterBusy), 32'd0);

        // Round robin with all four requesting; last winner was master 0
        bus.request = 4'b1111;
        exp_q.push_back(rr_exp[0]);
        tick();
        check("rr_grant", 32'(bus.grant), 32'(rr_exp[0]));
        for (int i = 1; i < 5; i++) begin
            bus.beginTransactionIn = 1'b1;
            tick();
            bus.beginTransactionIn = 1'b0;
            check("rr_hold", 32'(bus.grant), 32'(rr_exp[i-1]));
            bus.endTransactionIn = 1'b1;
            tick();
            bus.endTransactionIn = 1'b0;
            check("rr_gap", 32'(bus.grant), 32'd0);
            exp_q.push_back(rr_exp[i]);
            tick();
            check("rr_gap2", 32'(bus.grant), 32'd0);
            tick();
            check("rr_grant", 32'(bus.grant), 32'(rr_exp[i]));
        end

        // Abandon: master 1 drops, master 2 granted then drops, master 3 follows
        bus.request = 4'b0100;
        tick();
        check("abn1_grant", 32'(bus.grant), 32'd0);
        exp_q.push_back(4'b0100);
        tick();
        check("abn_grant2", 32'(bus.grant), 32'b0100);
        bus.request = 4'b1000;
        tick();
        check("abn_drop", 32'(bus.grant), 32'd0);
        check("abn_busy", 32'(bus.arbiterBusy), 32'd0);
        exp_q.push_back(4'b1000);
        tick();
        check("abn_next", 32'(bus.grant), 32'b1000);
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b1;
        tick();
        bus.endTransactionIn = 1'b0;
        bus.request = 4'b0000;
        tick();
        tick();

        // Mid-transaction reset while master 2 is active
        bus.request = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        check("mrst_grant", 32'(bus.grant), 32'b0100);
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        check("mrst_active", 32'(bus.arb_state), 32'd2);
        reset = 1'b1;
        tick();
        check("mrst_grant0", 32'(bus.grant), 32'd0);
        check("mrst_end", 32'(bus.endTransactionOut), 32'd0);
        check("mrst_err", 32'(bus.busErrorOut), 32'd0);
        check("mrst_busy", 32'(bus.arbiterBusy), 32'd0);
        reset = 1'b0;
        bus.request = 4'b0101;
        exp_q.push_back(4'b0001);
        tick();
        check("mrst_first", 32'(bus.grant), 32'b0001);
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        check("wd_active", 32'(bus.arb_state), 32'd2);

`ifdef SDRAM_ARBITER_WATCHDOG_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            check("wd_quiet", 32'(bus.busErrorOut), 32'd0);
            check("wd_held", 32'(bus.grant), 32'b0001);
        end
        tick();
        check("wd_err", 32'(bus.busErrorOut), 32'd1);
        check("wd_end", 32'(bus.endTransactionOut), 32'd1);
        check("wd_grant0", 32'(bus.grant), 32'd0);
        check("wd_release", 32'(bus.arb_state), 32'd3);
        tick();
        check("wd_pulse_len", 32'(bus.busErrorOut), 32'd0);

        // Collision: end strobe on the timeout cycle wins
        exp_q.push_back(4'b0100);
        tick();
        check("col_grant", 32'(bus.grant), 32'b0100);
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        bus.endTransactionIn = 1'b1;
        tick();
        bus.endTransactionIn = 1'b0;
        check("col_err", 32'(bus.busErrorOut), 32'd0);
        check("col_end", 32'(bus.endTransactionOut), 32'd0);
        check("col_release", 32'(bus.arb_state), 32'd3);
`else
        for (int i = 0; i < 100; i++) tick();
        check("nowd_held", 32'(bus.grant), 32'b0001);
        check("nowd_state", 32'(bus.arb_state), 32'd2);
        check("nowd_err", 32'(bus.busErrorOut), 32'd0);
        check("nowd_end", 32'(bus.endTransactionOut), 32'd0);
        bus.endTransactionIn = 1'b1;
        tick();
        bus.endTransactionIn = 1'b0;
        check("nowd_release", 32'(bus.arb_state), 32'd3);
`endif
        bus.request = 4'b0000;
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
